instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and program loader for the 16-bit, 3-bit-opcode processor. It accepts decoded instruction fields over a valid/ready handshake and packs them into the 16-bit word that the processor's control decode consumes. It range-checks the immediates and writes the words sequentially into instruction memory, with optional read-back verification. It sits between the host/debug loader path and the instruction memory write port.

## Interface
- ADDR_W, 8, instruction memory address width; depth = 2^ADDR_W words
- VERIFY, 1, 1 = read back and compare every write; 0 = write only
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_opcode  in  3  opcode class
- in_rs / in_rt / in_rd  in  3 each  register fields
- in_funct  in  4  R-type function field
- in_imm  in  16  immediate / jump target, two's complement
- base_load  in  1  load base_addr as write pointer; clear word_count
- base_addr  in  ADDR_W  new write pointer
- imem_we  out  1  memory write strobe
- imem_addr  out  ADDR_W  memory address
- imem_wdata  out  16  memory write data
- imem_rdata  in  16  memory read data; synchronous read with 1-cycle latency
- word_count  out  ADDR_W+1  words written since the last base_load or reset
- full  out  1  word_count == 2^ADDR_W
- busy  out  1  FSM not in IDLE
- err  out  1  one-cycle error pulse
- err_code  out  2  01 = immediate out of range, 10 = verify mismatch; held until the next err

## Operation
- Encoding:
  - R-type (000): {000, rs, rt, rd, funct}
  - I-type (001 slti, 100 lw, 101 sw, 110 beq, 111 addi): {op, rs, rt, imm[6:0]}
  - J-type (010 j, 011 jal): {op, imm[12:0]}
  - Fields that do not apply to a format are ignored.
- Range checks:
  - slti is zero-extended: imm must be 0..127.
  - Other I-types are sign-extended: imm must be -64..63.
  - J-types: imm must be 0..8191.
  - R-type is never rejected.
- FSM states: IDLE, ENC, WR, RD, CMP.
  - IDLE -> ENC on accept.
  - ENC: register the encoded word. On range fail, pulse err with code 01 and go to IDLE (no write). Otherwise go to WR.
  - WR: imem_we=1 for exactly one cycle. Go to RD if VERIFY=1, else go to IDLE and advance the pointer.
  - RD: imem_we=0, address held.
  - CMP: compare imem_rdata with the encoded word. On match, advance the pointer. On mismatch, pulse err with code 10 and do not advance. Go to IDLE.
- Pointer advance: imem_addr increments by 1, wrapping modulo 2^ADDR_W; word_count increments by 1.
- in_ready = IDLE & !full & !base_load (combinational).
- base_load is honoured in IDLE only and ignored elsewhere. If base_load and in_valid are both high in IDLE, base_load wins and nothing is accepted.
- When full: in_ready stays low until base_load or reset. The pointer has wrapped back to base_addr at that point.
- Reset values: in_ready=1 (after the reset edge), imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, full=0, busy=0, err=0, err_code=00, state=IDLE.
- Reset mid-operation aborts the transaction. If asserted during WR, imem_we is 0 from the reset edge onward. The partially handled bundle is discarded.

## Timing
- Accept at edge N (in_valid & in_ready).
- ENC occupies cycle N+1. WR occupies N+2 (imem_we high, imem_wdata valid).
- VERIFY=1: RD in N+3, CMP in N+4; in_ready high again in N+5, giving 5-cycle throughput.
- VERIFY=0: in_ready high again in N+3, giving 3-cycle throughput.
- Range error: err pulses during the cycle after ENC, together with in_ready returning.
- Verify error: err pulses during the cycle after CMP.
- imem_addr and imem_wdata are stable from WR through CMP.
- word_count and full update on the edge that leaves CMP (or WR when VERIFY=0).

## Test plan
- addi rs=0 rt=1 imm=5 at base 0 -> imem_wdata=0xE085 at addr 0, one imem_we pulse, word_count=1, no err.
- R-type rs=1 rt=2 rd=3 funct=0, then jal imm=0x0100 -> words 0x0530 then 0x6100 at consecutive addresses; in_ready low for exactly 4 cycles after each accept (VERIFY=1).
- lw rs=2 rt=3 imm=-1 -> 0x89FF. Then slti imm=-1 -> err with code 01, no imem_we. Then addi imm=64 -> err with code 01. word_count stays 1.
- Memory model corrupts bit 0 on readback -> err with code 10 in the cycle after CMP; imem_addr and word_count unchanged; a retry at the same address succeeds once corruption is removed.
- ADDR_W=2, base_addr=2, write 4 words -> addresses 2,3,0,1, full=1, in_ready=0. base_load clears word_count and full. base_load and in_valid together -> no accept.
- Reset asserted in the WR cycle -> imem_we=0 at the reset edge, all outputs at reset values; the next bundle is written to addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 16-bit words and writes them sequentially
// into instruction memory, with optional read-back verification.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter bit VERIFY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [3:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  input  logic [15:0]       imem_rdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ENC  = 3'd1,
    S_WR   = 3'd2,
    S_RD   = 3'd3,
    S_CMP  = 3'd4
  } state_t;

  function automatic logic [15:0] encode(input logic [2:0] op, input logic [2:0] rs,
                                         input logic [2:0] rt, input logic [2:0] rd,
                                         input logic [3:0] funct, input logic [15:0] imm);
    logic [15:0] w;
    case (op)
      3'b000:         w = {op, rs, rt, rd, funct};
      3'b010, 3'b011: w = {op, imm[12:0]};
      default:        w = {op, rs, rt, imm[6:0]};
    endcase
    return w;
  endfunction

  // slti zero-extends its immediate; the other I-types sign-extend theirs.
  function automatic logic imm_in_range(input logic [2:0] op, input logic [15:0] imm);
    logic ok;
    case (op)
      3'b000:         ok = 1'b1;
      3'b001:         ok = (imm[15:7] == 9'd0);
      3'b010, 3'b011: ok = (imm[15:13] == 3'd0);
      default:        ok = (imm[15:6] == 10'd0) || (imm[15:6] == 10'h3FF);
    endcase
    return ok;
  endfunction

  state_t            state_q;
  logic [2:0]        op_q, rs_q, rt_q, rd_q;
  logic [3:0]        funct_q;
  logic [15:0]       imm_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W:0]   count_q;
  logic              full_q;
  logic              err_q;
  logic [1:0]        code_q;

  logic [15:0]       enc_word_d;
  logic              imm_ok_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W:0]   count_d;
  logic              accept_d;

  assign enc_word_d = encode(op_q, rs_q, rt_q, rd_q, funct_q, imm_q);
  assign imm_ok_d   = imm_in_range(op_q, imm_q);
  assign addr_d     = addr_q + ADDR_ONE;
  assign count_d    = count_q + CNT_ONE;
  assign in_ready   = (state_q == S_IDLE) && !full_q && !base_load;
  assign accept_d   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      rs_q    <= 3'd0;
      rt_q    <= 3'd0;
      rd_q    <= 3'd0;
      funct_q <= 4'd0;
      imm_q   <= 16'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'd0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (base_load) begin
            addr_q  <= base_addr;
            count_q <= '0;
            full_q  <= 1'b0;
          end else if (accept_d) begin
            op_q    <= in_opcode;
            rs_q    <= in_rs;
            rt_q    <= in_rt;
            rd_q    <= in_rd;
            funct_q <= in_funct;
            imm_q   <= in_imm;
            state_q <= S_ENC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ENC: begin
          wdata_q <= enc_word_d;
          if (imm_ok_d) begin
            we_q    <= 1'b1;
            state_q <= S_WR;
          end else begin
            err_q   <= 1'b1;
            code_q  <= 2'b01;
            state_q <= S_IDLE;
          end
        end
        S_WR: begin
          we_q <= 1'b0;
          if (VERIFY) begin
            state_q <= S_RD;
          end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH);
            state_q <= S_IDLE;
          end
        end
        S_RD: state_q <= S_CMP;
        // Read data for the held address is valid in this cycle.
        S_CMP: begin
          if (imem_rdata == wdata_q) begin
            addr_q  <= addr_d;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH);
          end else begin
            err_q  <= 1'b1;
            code_q <= 2'b10;
          end
          state_q <= S_IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = count_q;
  assign full       = full_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a 4-word verifying instance with a scoreboarded memory
// monitor, plus a write-only 256-word instance for the short write path.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_valid, a_ready, a_bl, a_we, a_full, a_busy, a_err;
  logic [2:0]  a_op, a_rs, a_rt, a_rd, a_count;
  logic [3:0]  a_funct;
  logic [15:0] a_imm, a_wdata, a_rdata;
  logic [1:0]  a_base, a_addr, a_code;
  logic        corrupt;
  logic [15:0] a_mem [4];

  logic        b_valid, b_ready, b_bl, b_we, b_full, b_busy, b_err;
  logic [7:0]  b_base, b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic [8:0]  b_count;
  logic [1:0]  b_code;

  instr_encoder #(.ADDR_W(2), .VERIFY(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
    .in_opcode(a_op), .in_rs(a_rs), .in_rt(a_rt), .in_rd(a_rd), .in_funct(a_funct),
    .in_imm(a_imm), .base_load(a_bl), .base_addr(a_base), .imem_we(a_we),
    .imem_addr(a_addr), .imem_wdata(a_wdata), .imem_rdata(a_rdata),
    .word_count(a_count), .full(a_full), .busy(a_busy), .err(a_err), .err_code(a_code));

  instr_encoder #(.ADDR_W(8), .VERIFY(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
    .in_opcode(a_op), .in_rs(a_rs), .in_rt(a_rt), .in_rd(a_rd), .in_funct(a_funct),
    .in_imm(a_imm), .base_load(b_bl), .base_addr(b_base), .imem_we(b_we),
    .imem_addr(b_addr), .imem_wdata(b_wdata), .imem_rdata(b_rdata),
    .word_count(b_count), .full(b_full), .busy(b_busy), .err(b_err), .err_code(b_code));

  // Synchronous-read memory for instance A; corrupt flips bit 0 on read-back.
  always @(posedge clk) begin
    if (a_we) a_mem[a_addr] <= a_wdata;
    a_rdata <= a_mem[a_addr] ^ {15'd0, corrupt};
  end

  typedef struct {
    logic        bl;
    logic [2:0]  op, rs, rt, rd;
    logic [3:0]  funct;
    logic [15:0] imm;
    logic        bad;
    logic [15:0] word;
  } vec_t;

  typedef struct {
    logic        is_err;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [1:0]  code;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] exp_addr = 2'd0;
  int         exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe and error pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_we) begin
        if (exp_q.size() == 0 || exp_q[0].is_err) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_we: addr %0h data %0h, no write expected", a_addr, a_wdata);
        end else begin
          mon_ev = exp_q.pop_front();
          chk("we_addr", 32'(a_addr), 32'(mon_ev.addr));
          chk("we_data", 32'(a_wdata), 32'(mon_ev.data));
        end
      end
      if (a_err) begin
        if (exp_q.size() == 0 || !exp_q[0].is_err) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_err: code %0h, no error expected", a_code);
        end else begin
          mon_ev = exp_q.pop_front();
          chk("err_code", 32'(a_code), 32'(mon_ev.code));
        end
      end
    end
  end

  task automatic push_ev(input logic is_err, input logic [1:0] addr, input logic [15:0] data,
                         input logic [1:0] code);
    ev_t e;
    e.is_err = is_err; e.addr = addr; e.data = data; e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic send(input vec_t v, input bit mism);
    @(negedge clk);
    a_op = v.op; a_rs = v.rs; a_rt = v.rt; a_rd = v.rd; a_funct = v.funct; a_imm = v.imm;
    a_valid = 1'b1;
    chk("ready_at_accept", 32'(a_ready), 32'd1);
    if (v.bad) begin
      push_ev(1'b1, 2'd0, 16'd0, 2'b01);
    end else begin
      push_ev(1'b0, exp_addr, v.word, 2'b00);
      if (mism) begin
        push_ev(1'b1, 2'd0, 16'd0, 2'b10);
      end else begin
        exp_addr = exp_addr + 2'd1;
        exp_cnt++;
      end
    end
    @(posedge clk);
    #1 a_valid = 1'b0;
  endtask

  // Returns at the first negedge with the FSM idle; counts in_ready-low cycles before it.
  task automatic wait_idle(output int low);
    bit got = 1'b0;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!a_busy) begin got = 1'b1; break; end
      if (!a_ready) low++;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: busy still 1 after 20 cycles, expected 0");
    end
  endtask

  task automatic base_load_a(input logic [1:0] b);
    @(negedge clk);
    a_bl = 1'b1; a_base = b;
    @(posedge clk);
    #1 a_bl = 1'b0;
    exp_addr = b; exp_cnt = 0;
  endtask

  task automatic run_vec(input vec_t v, input bit mism);
    int low;
    send(v, mism);
    wait_idle(low);
    chk("err_timing", 32'(a_err), 32'(v.bad | mism));
    chk("ready_low_cycles", 32'(low), (v.bad ? 32'd1 : 32'd4));
    @(negedge clk);
    chk("events_done", 32'(exp_q.size()), 32'd0);
    chk("word_count", 32'(a_count), 32'(exp_cnt));
    chk("imem_addr", 32'(a_addr), 32'(exp_addr));
    chk("ready_after", 32'(a_ready), 32'(exp_cnt != 4));
  endtask

  vec_t tbl[10];
  vec_t v;

  initial begin
    tbl[0] = '{1'b1, 3'b111, 3'd0, 3'd1, 3'd0, 4'd0, 16'd5,      1'b0, 16'hE085};
    tbl[1] = '{1'b0, 3'b000, 3'd1, 3'd2, 3'd3, 4'd0, 16'hFFFF,   1'b0, 16'h0530};
    tbl[2] = '{1'b0, 3'b011, 3'd5, 3'd5, 3'd5, 4'd9, 16'h0100,   1'b0, 16'h6100};
    tbl[3] = '{1'b1, 3'b100, 3'd2, 3'd3, 3'd0, 4'd0, 16'hFFFF,   1'b0, 16'h89FF};
    tbl[4] = '{1'b0, 3'b001, 3'd0, 3'd0, 3'd0, 4'd0, 16'hFFFF,   1'b1, 16'h0000};
    tbl[5] = '{1'b0, 3'b111, 3'd0, 3'd1, 3'd0, 4'd0, 16'd64,     1'b1, 16'h0000};
    tbl[6] = '{1'b0, 3'b001, 3'd0, 3'd0, 3'd0, 4'd0, 16'd127,    1'b0, 16'h207F};
    tbl[7] = '{1'b0, 3'b010, 3'd0, 3'd0, 3'd0, 4'd0, 16'd8192,   1'b1, 16'h0000};
    tbl[8] = '{1'b0, 3'b111, 3'd0, 3'd0, 3'd0, 4'd0, 16'hFFC0,   1'b0, 16'hE040};
    tbl[9] = '{1'b0, 3'b010, 3'd0, 3'd0, 3'd0, 4'd0, 16'd8191,   1'b0, 16'h5FFF};

    reset = 1'b1; corrupt = 1'b0;
    a_valid = 1'b0; a_bl = 1'b0; a_base = 2'd0;
    a_op = 3'd0; a_rs = 3'd0; a_rt = 3'd0; a_rd = 3'd0; a_funct = 4'd0; a_imm = 16'd0;
    b_valid = 1'b0; b_bl = 1'b0; b_base = 8'd0; b_rdata = 16'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_outputs", {a_we, a_addr, a_wdata, a_count, a_full, a_busy, a_err, a_code}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].bl) base_load_a(2'd0);
      run_vec(tbl[i], 1'b0);
    end
    chk("full_after_4", 32'(a_full), 32'd1);

    // Valid held while full must be refused; the scoreboard flags any write.
    @(negedge clk);
    a_op = 3'b111; a_imm = 16'd3; a_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_busy", 32'(a_busy), 32'd0);
    chk("full_ready", 32'(a_ready), 32'd0);

    // base_load beats a simultaneous in_valid.
    a_bl = 1'b1; a_base = 2'd2;
    #1 chk("ready_with_bl", 32'(a_ready), 32'd0);
    @(posedge clk);
    #1 a_bl = 1'b0; a_valid = 1'b0;
    exp_addr = 2'd2; exp_cnt = 0;
    @(negedge clk);
    chk("bl_no_accept", 32'(a_busy), 32'd0);
    chk("bl_clear", {a_count, a_full, a_addr}, {27'd0, 3'd0, 1'b0, 2'd2});

    // Four R-type words from base 2 wrap through 3, 0, 1.
    for (int i = 0; i < 4; i++) begin
      v = '{1'b0, 3'b000, 3'(i), 3'(7 - i), 3'(i + 1), 4'(3 * i), 16'd0, 1'b0, 16'd0};
      v.word = {3'b000, v.rs, v.rt, v.rd, v.funct};
      run_vec(v, 1'b0);
    end
    chk("wrap_full", {a_full, a_ready, a_addr}, {28'd0, 1'b1, 1'b0, 2'd2});

    // Read-back corruption: error code 10, no advance; clean retry succeeds.
    base_load_a(2'd1);
    corrupt = 1'b1;
    run_vec(tbl[0], 1'b1);
    chk("mism_code_held", 32'(a_code), 32'd2);
    corrupt = 1'b0;
    run_vec(tbl[0], 1'b0);
    chk("code_held_after_ok", 32'(a_code), 32'd2);

    // Write-only instance: 3-cycle throughput.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_op = 3'b111; a_rs = 3'd0; a_rt = 3'd1; a_imm = 16'(k); b_valid = 1'b1;
      chk("b_ready_accept", 32'(b_ready), 32'd1);
      @(posedge clk);
      #1 b_valid = 1'b0;
      @(negedge clk);
      chk("b_enc", {b_we, b_ready}, 32'd0);
      @(negedge clk);
      chk("b_wr", {b_we, b_addr, b_wdata}, {7'd0, 1'b1, 8'(k), 16'hE080 | 16'(k)});
      @(negedge clk);
      chk("b_done", {b_we, b_ready, b_count, b_addr}, {13'd0, 1'b0, 1'b1, 9'(k + 1), 8'(k + 1)});
    end
    chk("b_flags", {b_full, b_busy, b_err, b_code}, 32'd0);

    // Reset during WR aborts the write and returns every output to reset values.
    @(negedge clk);
    a_op = 3'b111; a_rs = 3'd0; a_rt = 3'd1; a_imm = 16'd5; a_valid = 1'b1;
    push_ev(1'b0, exp_addr, 16'hE085, 2'b00);
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wr_before_reset", 32'(a_we), 32'd1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("mid_rst_outputs", {a_we, a_addr, a_wdata, a_count, a_full, a_busy, a_err, a_code}, 32'd0);
    chk("mid_rst_ready", 32'(a_ready), 32'd1);
    exp_addr = 2'd0; exp_cnt = 0;
    run_vec(tbl[1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end

endmodule
